// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, with a registered result stage.
module ex_muldiv_unit #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [REGW-1:0] rd_in,
    input  logic            ex_flush,
    input  logic            d_stall,
    output logic            stall_req,
    output logic            busy,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic [REGW-1:0] rd_out
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opb;
    logic [2:0]          r_op;
    logic [REGW-1:0]     r_rd;
    logic                r_neg_q, r_neg_r;
    logic [XLEN-1:0]     r_result;
    logic [REGW-1:0]     r_rd_out;
    logic                r_out_valid;

    logic                w_is_div, w_s1_signed, w_s2_signed, w_sign1, w_sign2;
    logic [XLEN-1:0]     w_mag1, w_mag2, w_special_res;
    logic                w_div_zero, w_ovf, w_special, w_accept, w_last;
    logic [XLEN:0]       w_mul_sum, w_div_trial;
    logic [2*XLEN-1:0]   w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod;
    logic [XLEN-1:0]     w_quot, w_rem, w_final;

    // Operand decode at acceptance: MULHU and the unsigned divides treat both operands unsigned,
    // MULHSU only rs1 signed.
    assign w_is_div    = funct3[2];
    assign w_s1_signed = w_is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign w_s2_signed = w_is_div ? ~funct3[0] : ~funct3[1];
    assign w_sign1     = w_s1_signed & rs1_data[XLEN-1];
    assign w_sign2     = w_s2_signed & rs2_data[XLEN-1];
    assign w_mag1      = w_sign1 ? -rs1_data : rs1_data;
    assign w_mag2      = w_sign2 ? -rs2_data : rs2_data;

    assign w_div_zero  = w_is_div & (rs2_data == '0);
    assign w_ovf       = w_is_div & ~funct3[0] & (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                         & (rs2_data == '1);
    assign w_special   = w_div_zero | w_ovf;
    assign w_special_res = w_div_zero ? (funct3[1] ? rs1_data : '1)
                                      : (funct3[1] ? '0 : rs1_data);

    assign w_accept    = (r_state == S_IDLE) & in_valid & ~ex_flush;
    assign w_last      = (r_state == S_BUSY) & ~ex_flush & (r_cnt == '0);

    // One iteration step: r_acc holds {high partial, multiplier} or {remainder, quotient}.
    assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_nxt   = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_div_trial = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]} - {1'b0, r_opb};
    assign w_div_nxt   = w_div_trial[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                           : {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    assign w_acc_nxt   = r_op[2] ? w_div_nxt : w_mul_nxt;

    assign w_prod  = r_neg_q ? -w_acc_nxt : w_acc_nxt;
    assign w_quot  = r_neg_q ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
    assign w_rem   = r_neg_r ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];
    assign w_final = r_op[2] ? (r_op[1] ? w_rem : w_quot)
                             : ((r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_special ? S_DONE : S_BUSY;
            S_BUSY: begin
                if (ex_flush)          w_state_nxt = S_IDLE;
                else if (r_cnt == '0)  w_state_nxt = S_DONE;
            end
            S_DONE: if (ex_flush || !d_stall) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_opb       <= '0;
            r_op        <= '0;
            r_rd        <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_result    <= '0;
            r_rd_out    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_acc   <= {{XLEN{1'b0}}, w_mag1};
                r_opb   <= w_mag2;
                r_op    <= funct3;
                r_rd    <= rd_in;
                r_neg_q <= w_sign1 ^ w_sign2;
                r_neg_r <= w_sign1;
                r_cnt   <= CW'(XLEN-1);
                if (w_special) begin
                    r_result <= w_special_res;
                    r_rd_out <= rd_in;
                end
            end else if (r_state == S_BUSY && !ex_flush) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt - 1'b1;
                if (w_last) begin
                    r_result <= w_final;
                    r_rd_out <= r_rd;
                end
            end
        end
    end

    assign stall_req = ~ex_flush & (((r_state == S_IDLE) & in_valid) | (r_state == S_BUSY));
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign rd_out    = r_rd_out;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit (XLEN=32): results, stall timing, flush, d_stall hold, reset.
module tb_ex_muldiv_unit;
    localparam int XLEN = 32;
    localparam int REGW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic [REGW-1:0] rd_in;
    logic            ex_flush, d_stall;
    logic            stall_req, busy, out_valid;
    logic [XLEN-1:0] result;
    logic [REGW-1:0] rd_out;

    int n_checks = 0;
    int n_errors = 0;

    ex_muldiv_unit #(.XLEN(XLEN), .REGW(REGW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
        .ex_flush(ex_flush), .d_stall(d_stall), .stall_req(stall_req),
        .busy(busy), .out_valid(out_valid), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Issue one op from IDLE, count stall_req cycles, check the DONE result, optionally hold via d_stall.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                          input int exp_stall, input int hold);
        int stall_cnt;
        @(negedge clk);
        funct3 = f3; rs1_data = a; rs2_data = b; rd_in = rd;
        in_valid = 1'b1; d_stall = (hold > 0);
        #1;
        stall_cnt = 0;
        while (stall_req && stall_cnt < 100) begin
            stall_cnt++;
            @(negedge clk); #1;
        end
        check({tag, " stall_cycles"}, 64'(stall_cnt), 64'(exp_stall));
        check({tag, " out_valid"}, 64'(out_valid), 64'd1);
        check({tag, " result"}, 64'(result), 64'(exp));
        check({tag, " rd_out"}, 64'(rd_out), 64'(rd));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            check({tag, " held_valid"}, 64'(out_valid), 64'd1);
            check({tag, " held_result"}, 64'(result), 64'(exp));
            check({tag, " no_restart"}, 64'(stall_req), 64'd0);
        end
        in_valid = 1'b0; d_stall = 1'b0;
        @(negedge clk); #1;
        check({tag, " valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, " idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; in_valid = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0;
        rd_in = '0; ex_flush = 1'b0; d_stall = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst result", 64'(result), 64'd0);
        check("rst rd_out", 64'(rd_out), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst stall_req", 64'(stall_req), 64'd0);
        rst = 1'b0;

        run_op("MUL",     3'b000, 32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 33, 0);
        run_op("MULH",    3'b001, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000, 33, 0);
        run_op("MULHU",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, 33, 0);
        run_op("MULHSU",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, 33, 0);
        run_op("DIV",     3'b100, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 33, 0);
        run_op("REM",     3'b110, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 33, 0);
        run_op("DIVU",    3'b101, 32'd100,      32'd7,        5'd9,  32'd14,       33, 0);
        run_op("REMU",    3'b111, 32'd100,      32'd7,        5'd10, 32'd2,        33, 0);
        run_op("DIVneg",  3'b100, 32'hFFFFFF9C, 32'd7,        5'd11, 32'hFFFFFFF2, 33, 0);
        run_op("REMneg",  3'b110, 32'hFFFFFF9C, 32'd7,        5'd12, 32'hFFFFFFFE, 33, 0);
        run_op("DIVUbig", 3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        33, 0);
        run_op("REMUbig", 3'b111, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 33, 0);
        run_op("DIVU/0",  3'b101, 32'd5,        32'd0,        5'd15, 32'hFFFFFFFF, 1,  0);
        run_op("REM/0",   3'b110, 32'd5,        32'd0,        5'd16, 32'd5,        1,  0);
        run_op("DIVovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 1,  0);
        run_op("REMovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0,        1,  0);

        // Flush while iterating: abort, no result, and the flush cycle accepts nothing.
        @(negedge clk);
        funct3 = 3'b000; rs1_data = 32'd5; rs2_data = 32'd6; rd_in = 5'd19; in_valid = 1'b1;
        repeat (11) @(negedge clk);
        ex_flush = 1'b1;
        #1;
        check("flush stall_req", 64'(stall_req), 64'd0);
        @(negedge clk);
        in_valid = 1'b0; ex_flush = 1'b0;
        #1;
        check("flush idle", 64'(busy), 64'd0);
        check("flush out_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        repeat (35) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush no_result", 64'(seen), 64'd0);
        run_op("MUL3x4", 3'b000, 32'd3, 32'd4, 5'd20, 32'd12, 33, 0);

        // Downstream stall in DONE holds the result stage.
        run_op("HOLD", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21, 32'hFFFFFFFE, 33, 3);

        // Reset mid-iteration clears everything on the next edge.
        @(negedge clk);
        funct3 = 3'b100; rs1_data = 32'd1000; rs2_data = 32'd3; rd_in = 5'd22; in_valid = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("mid busy", 64'(busy), 64'd1);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk); #1;
        check("mrst busy", 64'(busy), 64'd0);
        check("mrst out_valid", 64'(out_valid), 64'd0);
        check("mrst result", 64'(result), 64'd0);
        check("mrst rd_out", 64'(rd_out), 64'd0);
        check("mrst stall_req", 64'(stall_req), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
